// File: rtl/fetch_controller.sv
// fetch_controller: sequences the IF stage against a multi-cycle, handshaked
// instruction memory. One fetch is issued per PC value and the PC is frozen
// while it is outstanding. The fetched word is held until the pipeline
// accepts it, and a taken branch squashes any fetch still in flight.
// Optional feature macro: FETCH_TIMEOUT_EN (abort a fetch after
// TIMEOUT_CYCLES cycles without mem_ready and raise a sticky timeout_err).
module fetch_controller #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic        hazard_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        pc_freeze,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        mem_req_r;
  logic        mem_req_next_s;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_addr_next_s;
  logic        if_valid_r;
  logic        if_valid_next_s;
  logic [31:0] if_instr_r;
  logic [31:0] if_instr_next_s;
  logic        handoff_s;
  logic        timeout_hit_s;

  // The pipeline takes the held word this cycle, so the PC may advance.
  assign handoff_s = (state_r == ST_HOLD) & ~hazard_stall;
  // PC loads on a redirect or a handoff; it stays frozen throughout reset.
  assign pc_freeze = (~rst) | ~(branch_taken | handoff_s);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             timeout_err_r;

  // Count cycles spent waiting on memory; zero whenever no request is open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_REQ) || (state_r == ST_DROP)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // A late mem_ready in the final allowed cycle still wins over the abort.
  assign timeout_hit_s = ((state_r == ST_REQ) || (state_r == ST_DROP)) &&
                         (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_err_r | timeout_hit_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Next-state and next-output decode for the fetch sequencer.
  always_comb begin
    state_next_s    = state_r;
    mem_req_next_s  = mem_req_r;
    mem_addr_next_s = mem_addr_r;
    if_valid_next_s = if_valid_r;
    if_instr_next_s = if_instr_r;
    case (state_r)
      ST_IDLE: begin
        if (branch_taken) begin
          state_next_s = ST_IDLE;
        end else begin
          mem_req_next_s  = 1'b1;
          mem_addr_next_s = pc;
          state_next_s    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          mem_req_next_s = 1'b0;
          if (branch_taken) begin
            state_next_s = ST_IDLE;
          end else begin
            if_instr_next_s = mem_rdata;
            if_valid_next_s = 1'b1;
            state_next_s    = ST_HOLD;
          end
        end else if (timeout_hit_s) begin
          mem_req_next_s = 1'b0;
          if (branch_taken) begin
            state_next_s = ST_IDLE;
          end else begin
            if_instr_next_s = NOP_INSTR;
            if_valid_next_s = 1'b1;
            state_next_s    = ST_HOLD;
          end
        end else if (branch_taken) begin
          state_next_s = ST_DROP;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (branch_taken | ~hazard_stall) begin
          if_valid_next_s = 1'b0;
          state_next_s    = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (mem_ready | timeout_hit_s) begin
          mem_req_next_s = 1'b0;
          state_next_s   = ST_IDLE;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      default: begin
        mem_req_next_s  = 1'b0;
        if_valid_next_s = 1'b0;
        state_next_s    = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      if_valid_r <= 1'b0;
      if_instr_r <= NOP_INSTR;
    end else begin
      state_r    <= state_next_s;
      mem_req_r  <= mem_req_next_s;
      mem_addr_r <= mem_addr_next_s;
      if_valid_r <= if_valid_next_s;
      if_instr_r <= if_instr_next_s;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign if_valid = if_valid_r;
  assign if_instr = if_instr_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_controller;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        branch_taken;
  logic        hazard_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        pc_freeze;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        timeout_err;

  logic [31:0] br_target;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

`ifdef FETCH_TIMEOUT_EN
  fetch_controller #(.NOP_INSTR(NOP), .TIMEOUT_CYCLES(4)) dut (
`else
  fetch_controller #(.NOP_INSTR(NOP)) dut (
`endif
    .clk(clk), .rst(rst), .pc(pc), .branch_taken(branch_taken),
    .hazard_stall(hazard_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc_freeze(pc_freeze),
    .if_valid(if_valid), .if_instr(if_instr), .timeout_err(timeout_err)
  );

  // One clock cycle; the bench plays the PC register (loads when unfrozen).
  task automatic tick();
    logic fz;
    logic bt;
    #1;
    fz = pc_freeze;
    bt = branch_taken;
    @(posedge clk);
    #1;
    if (!fz) pc = bt ? br_target : pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b0; branch_taken = 1'b0; hazard_stall = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0; pc = 32'h0; br_target = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; branch_taken = 1'b1; hazard_stall = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0; pc = 32'h0; br_target = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    vec_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_if_valid: got %0b want 0", if_valid); end
    vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL reset_if_instr: got %h want %h", if_instr, NOP); end
    vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
    vec_cnt++; if (pc_freeze !== 1'b1) begin err_cnt++; $display("FAIL reset_pc_freeze: got %0b want 1", pc_freeze); end
    branch_taken = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_basic_fetch();
    #1;
    vec_cnt++; if (pc_freeze !== 1'b1) begin err_cnt++; $display("FAIL basic_idle_freeze: got %0b want 1", pc_freeze); end
    tick();
    vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL basic_req: got %0b want 1", mem_req); end
    vec_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL basic_addr0: got %h want 0", mem_addr); end
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_novalid: got %0b want 0", if_valid); end
    tick();
    vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL basic_req_held: got %0b want 1", mem_req); end
    vec_cnt++; if (pc_freeze !== 1'b1) begin err_cnt++; $display("FAIL basic_req_freeze: got %0b want 1", pc_freeze); end
    mem_ready = 1'b1; mem_rdata = 32'hE3A0_1005;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid: got %0b want 1", if_valid); end
    vec_cnt++; if (if_instr !== 32'hE3A0_1005) begin err_cnt++; $display("FAIL basic_instr: got %h want e3a01005", if_instr); end
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL basic_req_drop: got %0b want 0", mem_req); end
    vec_cnt++; if (pc_freeze !== 1'b0) begin err_cnt++; $display("FAIL basic_handoff_freeze: got %0b want 0", pc_freeze); end
    tick();
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_valid_fall: got %0b want 0", if_valid); end
    vec_cnt++; if (pc_freeze !== 1'b1) begin err_cnt++; $display("FAIL basic_freeze_once: got %0b want 1", pc_freeze); end
    tick();
    vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL basic_req2: got %0b want 1", mem_req); end
    vec_cnt++; if (mem_addr !== 32'h4) begin err_cnt++; $display("FAIL basic_addr4: got %h want 4", mem_addr); end
  endtask

  task automatic test_hazard_hold();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_valid[%0d]: got %0b want 1", i, if_valid); end
      vec_cnt++; if (if_instr !== 32'h1234_5678) begin err_cnt++; $display("FAIL hold_instr[%0d]: got %h want 12345678", i, if_instr); end
      vec_cnt++; if (pc_freeze !== 1'b1) begin err_cnt++; $display("FAIL hold_freeze[%0d]: got %0b want 1", i, pc_freeze); end
      vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL hold_noreq[%0d]: got %0b want 0", i, mem_req); end
      tick();
    end
    hazard_stall = 1'b0;
    #1;
    vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_valid4: got %0b want 1", if_valid); end
    vec_cnt++; if (pc_freeze !== 1'b0) begin err_cnt++; $display("FAIL hold_handoff: got %0b want 0", pc_freeze); end
    tick();
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_valid_fall: got %0b want 0", if_valid); end
    vec_cnt++; if (if_instr !== 32'h1234_5678) begin err_cnt++; $display("FAIL hold_instr_kept: got %h want 12345678", if_instr); end
    tick();
    vec_cnt++; if (mem_addr !== 32'h8) begin err_cnt++; $display("FAIL hold_next_addr: got %h want 8", mem_addr); end
  endtask

  task automatic test_branch_in_req();
    branch_taken = 1'b1; br_target = 32'h40;
    #1;
    vec_cnt++; if (pc_freeze !== 1'b0) begin err_cnt++; $display("FAIL brreq_freeze: got %0b want 0", pc_freeze); end
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL brreq_kept[%0d]: got %0b want 1", i, mem_req); end
      vec_cnt++; if (mem_addr !== 32'h8) begin err_cnt++; $display("FAIL brreq_addr[%0d]: got %h want 8", i, mem_addr); end
      if (i == 0) tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL brreq_dropped: got %0b want 0", if_valid); end
    vec_cnt++; if (if_instr !== 32'h1234_5678) begin err_cnt++; $display("FAIL brreq_instr: got %h want 12345678", if_instr); end
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL brreq_req_drop: got %0b want 0", mem_req); end
    tick();
    vec_cnt++; if (mem_addr !== 32'h40) begin err_cnt++; $display("FAIL brreq_target: got %h want 40", mem_addr); end
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL brreq_valid2: got %0b want 0", if_valid); end
  endtask

  task automatic test_branch_with_ready();
    branch_taken = 1'b1; br_target = 32'h80;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    branch_taken = 1'b0; mem_ready = 1'b0;
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL brrdy_req: got %0b want 0", mem_req); end
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL brrdy_valid: got %0b want 0", if_valid); end
    tick();
    vec_cnt++; if (mem_addr !== 32'h80) begin err_cnt++; $display("FAIL brrdy_target: got %h want 80", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ready = 1'b0;
    vec_cnt++; if (if_instr !== 32'h1111_2222) begin err_cnt++; $display("FAIL brhold_instr: got %h want 11112222", if_instr); end
    hazard_stall = 1'b1; branch_taken = 1'b1; br_target = 32'hC0;
    #1;
    vec_cnt++; if (pc_freeze !== 1'b0) begin err_cnt++; $display("FAIL brhold_freeze: got %0b want 0", pc_freeze); end
    tick();
    hazard_stall = 1'b0; branch_taken = 1'b0;
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL brhold_valid: got %0b want 0", if_valid); end
    tick();
    vec_cnt++; if (mem_addr !== 32'hC0) begin err_cnt++; $display("FAIL brhold_target: got %h want c0", mem_addr); end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL arst_req: got %0b want 0", mem_req); end
    vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL arst_valid: got %0b want 0", if_valid); end
    vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL arst_instr: got %h want %h", if_instr, NOP); end
    vec_cnt++; if (pc_freeze !== 1'b1) begin err_cnt++; $display("FAIL arst_freeze: got %0b want 1", pc_freeze); end
    do_reset();
  endtask

  task automatic test_random();
    bit          m_busy;
    bit          m_squash;
    bit          m_have;
    logic [31:0] m_addr;
    logic [31:0] m_word;
    logic        exp_freeze;
    int          lat;
    do_reset();
    m_busy = 1'b0; m_squash = 1'b0; m_have = 1'b0;
    m_addr = 32'h0; m_word = NOP; lat = 0;
    for (int c = 0; c < 800; c++) begin
      branch_taken = ($urandom_range(0, 99) < 15);
      br_target    = $urandom() & 32'hFFFF_FFFC;
      hazard_stall = ($urandom_range(0, 99) < 40);
      if (mem_req) begin
        if (lat == 0) begin
          mem_ready = 1'b1; mem_rdata = $urandom(); lat = $urandom_range(0, 3);
        end else begin
          mem_ready = 1'b0; lat--;
        end
      end else begin
        mem_ready = ($urandom_range(0, 9) == 0);
        mem_rdata = $urandom();
      end
      #1;
      exp_freeze = !(branch_taken || (m_have && !hazard_stall));
      vec_cnt++; if (pc_freeze !== exp_freeze) begin err_cnt++; $display("FAIL rnd_freeze c%0d: got %0b want %0b", c, pc_freeze, exp_freeze); end
      // Transaction-level model: one open request, squash flag, held word.
      if (m_busy) begin
        if (mem_ready) begin
          m_busy = 1'b0;
          if (!m_squash && !branch_taken) begin m_have = 1'b1; m_word = mem_rdata; end
        end else if (branch_taken) begin
          m_squash = 1'b1;
        end
      end else if (m_have) begin
        if (branch_taken || !hazard_stall) m_have = 1'b0;
      end else if (!branch_taken) begin
        m_busy = 1'b1; m_squash = 1'b0; m_addr = pc;
      end
      tick();
      vec_cnt++; if (mem_req !== m_busy) begin err_cnt++; $display("FAIL rnd_req c%0d: got %0b want %0b", c, mem_req, m_busy); end
      if (m_busy) begin
        vec_cnt++; if (mem_addr !== m_addr) begin err_cnt++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, m_addr); end
      end
      vec_cnt++; if (if_valid !== m_have) begin err_cnt++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, if_valid, m_have); end
      vec_cnt++; if (if_instr !== m_word) begin err_cnt++; $display("FAIL rnd_instr c%0d: got %h want %h", c, if_instr, m_word); end
      vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL rnd_tmo c%0d: got %0b want 0", c, timeout_err); end
    end
    branch_taken = 1'b0; hazard_stall = 1'b0; mem_ready = 1'b0;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hABCD_0001;
    tick();
    mem_ready = 1'b0;
    vec_cnt++; if (if_instr !== 32'hABCD_0001) begin err_cnt++; $display("FAIL tmo_pre_instr: got %h want abcd0001", if_instr); end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL tmo_wait_req[%0d]: got %0b want 1", i, mem_req); end
      vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL tmo_wait_err[%0d]: got %0b want 0", i, timeout_err); end
      tick();
    end
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL tmo_req: got %0b want 0", mem_req); end
    vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL tmo_valid: got %0b want 1", if_valid); end
    vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL tmo_instr: got %h want %h", if_instr, NOP); end
    vec_cnt++; if (timeout_err !== 1'b1) begin err_cnt++; $display("FAIL tmo_err: got %0b want 1", timeout_err); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (timeout_err !== 1'b1) begin err_cnt++; $display("FAIL tmo_sticky[%0d]: got %0b want 1", i, timeout_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fetch();
    test_hazard_hold();
    test_branch_in_req();
    test_branch_with_ready();
    test_async_reset();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
